// File: rtl/display_pkg.sv
// Shared geometry, control codes and state encoding for the text display path.
package display_pkg;

  localparam int COLS   = 64;
  localparam int ROWS   = 32;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int ADDR_W = COL_W + ROW_W;
  localparam int RAM_AW = 12;

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CELL_MAX = ADDR_W'(COLS * ROWS - 1);

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console.sv
// Byte-stream front end for char_ram: interprets control codes, tracks the cursor,
// scrolls via a top-row offset and blanks lines/screen one cell per cycle.
module text_console
  import display_pkg::*;
(
  input  logic              CPUClk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [ROW_W-1:0]  scroll_row,
  output logic [RAM_AW-1:0] cursor_addr
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_n;
  logic [COL_W-1:0]    col, col_n;
  logic [ROW_W-1:0]    crow, crow_n, top, top_n, old_top, old_top_n;
  logic [ROW_W-1:0]    cur_phys, phys_n;
  logic                ready_n, we_n, do_adv;
  logic [RAM_AW-1:0]   waddr_n;
  logic [7:0]          wdata_n;

  assign cur_phys   = crow + top;
  assign scroll_row = top;

  always_ff @(posedge CPUClk or negedge rst_n) begin
    if (!rst_n) state <= CLR_SCREEN;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    col_n     = col;
    crow_n    = crow;
    top_n     = top;
    old_top_n = old_top;
    ready_n   = 1'b0;
    we_n      = 1'b0;
    waddr_n   = ram_waddr;
    wdata_n   = ram_wdata;
    do_adv    = 1'b0;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (in_valid && in_ready) begin
          if (is_printable(in_data)) begin
            we_n    = 1'b1;
            waddr_n = RAM_AW'({cur_phys, col});
            wdata_n = in_data;
            if (col == COL_MAX) begin
              col_n  = '0;
              do_adv = 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end else if (in_data == CC_LF) begin
            col_n  = '0;
            do_adv = 1'b1;
          end else if (in_data == CC_CR) begin
            col_n = '0;
          end else if (in_data == CC_BS) begin
            if (col != '0) begin
              col_n   = col - 1'b1;
              we_n    = 1'b1;
              waddr_n = RAM_AW'({cur_phys, col - 1'b1});
              wdata_n = BLANK;
            end
          end else if (in_data == CC_FF) begin
            crow_n    = '0;
            col_n     = '0;
            top_n     = '0;
            clr_cnt_n = '0;
            ready_n   = 1'b0;
            state_n   = CLR_SCREEN;
          end
        end
        // Bottom-row advance keeps crow fixed and rotates the physical top row instead.
        if (do_adv) begin
          if (crow != ROW_MAX) begin
            crow_n = crow + 1'b1;
          end else begin
            old_top_n = top;
            top_n     = top + 1'b1;
            clr_cnt_n = '0;
            ready_n   = 1'b0;
            state_n   = CLR_LINE;
          end
        end
      end
      CLR_LINE: begin
        we_n      = 1'b1;
        waddr_n   = RAM_AW'({old_top, clr_cnt[COL_W-1:0]});
        wdata_n   = BLANK;
        clr_cnt_n = clr_cnt + 1'b1;
        if (clr_cnt[COL_W-1:0] == COL_MAX) state_n = IDLE;
      end
      CLR_SCREEN: begin
        we_n      = 1'b1;
        waddr_n   = RAM_AW'(clr_cnt);
        wdata_n   = BLANK;
        clr_cnt_n = clr_cnt + 1'b1;
        if (clr_cnt == CELL_MAX) state_n = IDLE;
      end
      default: state_n = CLR_SCREEN;
    endcase
    phys_n = crow_n + top_n;
  end

  always_ff @(posedge CPUClk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt     <= '0;
      col         <= '0;
      crow        <= '0;
      top         <= '0;
      old_top     <= '0;
      in_ready    <= 1'b0;
      ram_we      <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= BLANK;
      cursor_addr <= '0;
    end else begin
      clr_cnt     <= clr_cnt_n;
      col         <= col_n;
      crow        <= crow_n;
      top         <= top_n;
      old_top     <= old_top_n;
      in_ready    <= ready_n;
      ram_we      <= we_n;
      ram_waddr   <= waddr_n;
      ram_wdata   <= wdata_n;
      cursor_addr <= RAM_AW'({phys_n, col_n});
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: stimulus queues expected char_ram writes,
// a forked monitor pops and compares them whenever ram_we is seen.
module tb_text_console;
  import display_pkg::*;

  logic              CPUClk = 1'b0;
  logic              rst_n  = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [RAM_AW-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [ROW_W-1:0]  scroll_row;
  logic [RAM_AW-1:0] cursor_addr;

  logic [19:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  text_console dut (
    .CPUClk     (CPUClk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .scroll_row (scroll_row),
    .cursor_addr(cursor_addr)
  );

  always #5 CPUClk = ~CPUClk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic pushWrite(input int addr, input logic [7:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic pushBlanks(input int base, input int count);
    for (int i = 0; i < count; i++) pushWrite(base + i, BLANK);
  endtask

  task automatic monitor();
    logic [19:0] e;
    forever begin
      @(negedge CPUClk);
      if (rst_n && ram_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", ram_waddr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ram_write", {12'h0, ram_waddr, ram_wdata}, {12'h0, e});
        end
      end
    end
  endtask

  // Called at posedge+1; returns at accept edge+1 with the number of stalled edges.
  task automatic applyStimulus(input logic [7:0] b, input int budget, output int waits);
    logic rdy;
    waits    = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge CPUClk);
      rdy = in_ready;
      @(posedge CPUClk);
      if (rdy) break;
      waits++;
      if (waits > budget) begin
        checks++;
        $display("[TB] FAIL accept_timeout: byte 0x%0h not accepted within %0d cycles", b, budget);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitReady(input string name, input int expected);
    int n;
    n = 0;
    while (n < 5000) begin
      @(posedge CPUClk);
      #1;
      n++;
      if (in_ready) break;
    end
    checkOutput(name, n, expected);
  endtask

  task automatic sendMany(input logic [7:0] b, input int count);
    int w;
    for (int i = 0; i < count; i++) applyStimulus(b, 100, w);
  endtask

  initial begin
    int w;
    fork
      monitor();
    join_none

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_ram_we", ram_we, 0);
    checkOutput("reset_waddr", ram_waddr, 0);
    checkOutput("reset_wdata", ram_wdata, 8'h20);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_scroll_row", scroll_row, 0);
    checkOutput("reset_cursor", cursor_addr, 0);
    repeat (3) @(posedge CPUClk);
    #1;
    pushBlanks(0, 2048);
    rst_n = 1'b1;
    waitReady("init_clear_cycles", 2049);
    checkOutput("init_cursor", cursor_addr, 0);

    pushWrite(0, 8'h41);
    pushWrite(1, 8'h42);
    applyStimulus(8'h41, 100, w);
    checkOutput("A_no_stall", w, 0);
    applyStimulus(8'h42, 100, w);
    checkOutput("B_no_stall", w, 0);
    checkOutput("AB_cursor", cursor_addr, 2);

    for (int i = 2; i < 64; i++) begin
      pushWrite(i, 8'h41 + 8'(i % 26));
      applyStimulus(8'h41 + 8'(i % 26), 100, w);
    end
    checkOutput("row0_full_cursor", cursor_addr, 64);
    applyStimulus(CC_CR, 100, w);
    checkOutput("cr_cursor", cursor_addr, 64);
    applyStimulus(CC_BS, 100, w);
    checkOutput("bs_col0_cursor", cursor_addr, 64);
    applyStimulus(8'h07, 100, w);
    applyStimulus(8'h9A, 100, w);
    checkOutput("ignored_cursor", cursor_addr, 64);
    pushWrite(64, 8'h58);
    applyStimulus(8'h58, 100, w);
    checkOutput("X_cursor", cursor_addr, 65);
    pushWrite(64, BLANK);
    applyStimulus(CC_BS, 100, w);
    checkOutput("bs_cursor", cursor_addr, 64);

    sendMany(CC_LF, 30);
    checkOutput("bottom_cursor", cursor_addr, 31 * 64);
    checkOutput("bottom_scroll_row", scroll_row, 0);
    pushBlanks(0, 64);
    applyStimulus(CC_LF, 100, w);
    checkOutput("scroll1_row", scroll_row, 1);
    checkOutput("scroll1_cursor", cursor_addr, 0);
    checkOutput("scroll1_ready", in_ready, 0);
    waitReady("scroll1_stall", 65);
    pushWrite(0, 8'h5A);
    applyStimulus(8'h5A, 100, w);
    checkOutput("Z_cursor", cursor_addr, 1);

    for (int k = 1; k <= 4; k++) begin
      pushBlanks(k * 64, 64);
      applyStimulus(CC_LF, 100, w);
      waitReady("scrollk_stall", 65);
    end
    checkOutput("top5_scroll_row", scroll_row, 5);
    checkOutput("top5_cursor", cursor_addr, 4 * 64);

    pushBlanks(0, 2048);
    applyStimulus(CC_FF, 100, w);
    checkOutput("ff_scroll_row", scroll_row, 0);
    checkOutput("ff_cursor", cursor_addr, 0);
    pushWrite(0, 8'h51);
    applyStimulus(8'h51, 3000, w);
    checkOutput("held_byte_stall", w, 2049);
    checkOutput("Q_cursor", cursor_addr, 1);
    repeat (2) @(posedge CPUClk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);

    sendMany(CC_LF, 31);
    checkOutput("pre_abort_cursor", cursor_addr, 31 * 64 + 0);
    pushBlanks(0, 64);
    applyStimulus(CC_LF, 100, w);
    repeat (10) @(posedge CPUClk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ram_we", ram_we, 0);
    checkOutput("abort_waddr", ram_waddr, 0);
    checkOutput("abort_wdata", ram_wdata, 8'h20);
    checkOutput("abort_in_ready", in_ready, 0);
    checkOutput("abort_scroll_row", scroll_row, 0);
    checkOutput("abort_cursor", cursor_addr, 0);
    checkOutput("abort_pending", exp_q.size(), 55);
    exp_q.delete();
    repeat (2) @(posedge CPUClk);
    #1;
    pushBlanks(0, 2048);
    rst_n = 1'b1;
    waitReady("restart_clear_cycles", 2049);
    checkOutput("restart_cursor", cursor_addr, 0);
    repeat (2) @(posedge CPUClk);
    #1;
    checkOutput("final_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
